consumer_checker: RTL and testbench

CONSUMER_CHECKER -- requirements
Module: consumer_checker

---
 rtl/consumer_checker_pkg.sv | 8 +
 rtl/consumer_checker_if.sv | 26 ++
 rtl/consumer_checker_lane_checker.sv | 65 ++++++
 rtl/consumer_checker.sv | 52 +++++
 tb/tb_consumer_checker.sv | 130 +++++++++++++
 5 files changed

// File: rtl/consumer_checker_pkg.sv
// consumer_checker_pkg: shared lane-state enum and default parameters
// Contents: lane_state_t (SYNC/CHECK/ERROR), DEF_STEP, DEF_STALL_PERIOD, DEF_STALL_LEN
package consumer_checker_pkg;
    typedef enum logic [1:0] {SYNC, CHECK, ERROR} lane_state_t;
    localparam int DEF_STEP = 2;
    localparam int DEF_STALL_PERIOD = 16;
    localparam int DEF_STALL_LEN = 3;
endpackage

// File: rtl/consumer_checker_if.sv
// consumer_checker_if: producer/checker bundle for the two-lane consumer checker
// master: drives lane data, valid, flushes and stall_en; receives stalls, err, counts, mismatch data
// slave: the checker side of the same signals
interface consumer_checker_if;
    logic [31:0] pipeline1_outputs;
    logic [31:0] pipeline2_outputs;
    logic [1:0]  out_valid;
    logic        flush_1;
    logic        flush_2;
    logic        stall_en;
    logic        stall_1;
    logic        stall_2;
    logic [1:0]  err;
    logic [15:0] match_count_1;
    logic [15:0] match_count_2;
    logic [31:0] mismatch_data_1;
    logic [31:0] mismatch_data_2;
    modport master (
        output pipeline1_outputs, pipeline2_outputs, out_valid, flush_1, flush_2, stall_en,
        input  stall_1, stall_2, err, match_count_1, match_count_2, mismatch_data_1, mismatch_data_2
    );
    modport slave (
        input  pipeline1_outputs, pipeline2_outputs, out_valid, flush_1, flush_2, stall_en,
        output stall_1, stall_2, err, match_count_1, match_count_2, mismatch_data_1, mismatch_data_2
    );
endinterface

// File: rtl/consumer_checker_lane_checker.sv
// lane_checker: per-lane sequence checker (SYNC -> CHECK -> ERROR) with flush resync
// Ports: clk, reset_n (async, active-low), data/valid/flush in; err, match_count, mismatch_data out
module lane_checker
    import consumer_checker_pkg::*;
#(
    parameter int STEP = DEF_STEP
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data,
    input  logic        valid,
    input  logic        flush,
    output logic        err,
    output logic [15:0] match_count,
    output logic [31:0] mismatch_data
);
    lane_state_t state, state_n;
    logic [31:0] expected, expected_n, mismatch_n;
    logic [15:0] count_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= SYNC;
            expected      <= '0;
            match_count   <= '0;
            mismatch_data <= '0;
        end else begin
            state         <= state_n;
            expected      <= expected_n;
            match_count   <= count_n;
            mismatch_data <= mismatch_n;
        end
    end

    // flush wins over a same-cycle beat; the count survives a flush
    always_comb begin
        state_n    = state;
        expected_n = expected;
        count_n    = match_count;
        mismatch_n = mismatch_data;
        if (flush) begin
            state_n    = SYNC;
            mismatch_n = '0;
        end else if (valid) begin
            case (state)
                SYNC: begin
                    expected_n = data + 32'(STEP);
                    state_n    = CHECK;
                end
                CHECK: begin
                    if (data == expected) begin
                        expected_n = data + 32'(STEP);
                        count_n    = match_count + {15'd0, ~&match_count};
                    end else begin
                        state_n    = ERROR;
                        mismatch_n = data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err = state == ERROR;
endmodule

// File: rtl/consumer_checker.sv
// consumer_checker: two independent lane checkers plus a periodic backpressure generator
// Ports: clk, reset_n (async, active-low), bus (consumer_checker_if.slave) carrying lane data,
// valids, flushes, stall_en in and stall_1/2, err, match counts, mismatch data out
module consumer_checker
    import consumer_checker_pkg::*;
#(
    parameter int STEP         = DEF_STEP,
    parameter int STALL_PERIOD = DEF_STALL_PERIOD,
    parameter int STALL_LEN    = DEF_STALL_LEN
) (
    input logic clk,
    input logic reset_n,
    consumer_checker_if.slave bus
);
    localparam int CW = $clog2(STALL_PERIOD + 1);

    logic [CW-1:0] cnt;
    logic [31:0]   shifted_raw, shifted;
    logic          err_1, err_2;

    lane_checker #(.STEP(STEP)) u_lane_1 (
        .clk(clk), .reset_n(reset_n),
        .data(bus.pipeline1_outputs), .valid(bus.out_valid[0]), .flush(bus.flush_1),
        .err(err_1), .match_count(bus.match_count_1), .mismatch_data(bus.mismatch_data_1)
    );

    lane_checker #(.STEP(STEP)) u_lane_2 (
        .clk(clk), .reset_n(reset_n),
        .data(bus.pipeline2_outputs), .valid(bus.out_valid[1]), .flush(bus.flush_2),
        .err(err_2), .match_count(bus.match_count_2), .mismatch_data(bus.mismatch_data_2)
    );

    assign bus.err = {err_2, err_1};

    // lane 2 sees the counter rotated by half a period
    always_comb begin
        shifted_raw = 32'(cnt) + 32'(STALL_PERIOD - STALL_PERIOD / 2);
        shifted     = shifted_raw >= 32'(STALL_PERIOD) ? shifted_raw - 32'(STALL_PERIOD) : shifted_raw;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            bus.stall_1 <= 1'b0;
            bus.stall_2 <= 1'b0;
        end else begin
            cnt         <= cnt == CW'(STALL_PERIOD - 1) ? '0 : cnt + CW'(1);
            bus.stall_1 <= bus.stall_en && cnt < CW'(STALL_LEN);
            bus.stall_2 <= bus.stall_en && shifted < 32'(STALL_LEN);
        end
    end
endmodule

// File: tb/tb_consumer_checker.sv
// tb_consumer_checker: directed table-driven bench for consumer_checker with default parameters
module tb_consumer_checker;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    consumer_checker_if bus ();
    consumer_checker dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [1:0]  v;
        logic        f1, f2;
        logic [31:0] d1, d2;
        logic [1:0]  err;
        logic [15:0] m1, m2;
        logic [31:0] mm1, mm2;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic chk_lanes(input string n, input logic [1:0] e, input logic [15:0] m1, input logic [15:0] m2,
                             input logic [31:0] mm1, input logic [31:0] mm2);
        chk({n, ".err"}, 32'(bus.err), 32'(e));
        chk({n, ".mc1"}, 32'(bus.match_count_1), 32'(m1));
        chk({n, ".mc2"}, 32'(bus.match_count_2), 32'(m2));
        chk({n, ".mm1"}, bus.mismatch_data_1, mm1);
        chk({n, ".mm2"}, bus.mismatch_data_2, mm2);
    endtask

    task automatic chk_zero(input string n);
        chk_lanes(n, 2'b00, 16'd0, 16'd0, 32'd0, 32'd0);
        chk({n, ".stall1"}, 32'(bus.stall_1), 32'd0);
        chk({n, ".stall2"}, 32'(bus.stall_2), 32'd0);
    endtask

    // drive at a falling edge, let one rising edge sample it, return at the next falling edge
    task automatic beat(input logic [1:0] v, input logic [31:0] d1, input logic [31:0] d2,
                        input logic f1, input logic f2);
        bus.out_valid = v;
        bus.pipeline1_outputs = d1;
        bus.pipeline2_outputs = d2;
        bus.flush_1 = f1;
        bus.flush_2 = f2;
        @(negedge clk);
        bus.out_valid = 2'b00;
        bus.flush_1 = 1'b0;
        bus.flush_2 = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{2'b11, 1'b0, 1'b0, 32'd0,        32'd1,  2'b00, 16'd0, 16'd0, 32'd0, 32'd0};
        tbl[1]  = '{2'b11, 1'b0, 1'b0, 32'd2,        32'd3,  2'b00, 16'd1, 16'd1, 32'd0, 32'd0};
        tbl[2]  = '{2'b11, 1'b0, 1'b0, 32'd4,        32'd9,  2'b10, 16'd2, 16'd1, 32'd0, 32'd9};
        tbl[3]  = '{2'b11, 1'b0, 1'b0, 32'd6,        32'd11, 2'b10, 16'd3, 16'd1, 32'd0, 32'd9};
        tbl[4]  = '{2'b10, 1'b0, 1'b0, 32'd0,        32'd13, 2'b10, 16'd3, 16'd1, 32'd0, 32'd9};
        tbl[5]  = '{2'b00, 1'b0, 1'b1, 32'd0,        32'd0,  2'b00, 16'd3, 16'd1, 32'd0, 32'd0};
        tbl[6]  = '{2'b10, 1'b0, 1'b0, 32'd0,        32'd11, 2'b00, 16'd3, 16'd1, 32'd0, 32'd0};
        tbl[7]  = '{2'b10, 1'b0, 1'b0, 32'd0,        32'd13, 2'b00, 16'd3, 16'd2, 32'd0, 32'd0};
        tbl[8]  = '{2'b00, 1'b1, 1'b0, 32'd0,        32'd0,  2'b00, 16'd3, 16'd2, 32'd0, 32'd0};
        tbl[9]  = '{2'b01, 1'b0, 1'b0, 32'hFFFFFFFC, 32'd0,  2'b00, 16'd3, 16'd2, 32'd0, 32'd0};
        tbl[10] = '{2'b01, 1'b0, 1'b0, 32'hFFFFFFFE, 32'd0,  2'b00, 16'd4, 16'd2, 32'd0, 32'd0};
        tbl[11] = '{2'b01, 1'b0, 1'b0, 32'h00000000, 32'd0,  2'b00, 16'd5, 16'd2, 32'd0, 32'd0};
        tbl[12] = '{2'b01, 1'b1, 1'b0, 32'd5,        32'd0,  2'b00, 16'd5, 16'd2, 32'd0, 32'd0};
        tbl[13] = '{2'b01, 1'b0, 1'b0, 32'd100,      32'd0,  2'b00, 16'd5, 16'd2, 32'd0, 32'd0};
        tbl[14] = '{2'b01, 1'b0, 1'b0, 32'd102,      32'd0,  2'b00, 16'd6, 16'd2, 32'd0, 32'd0};

        bus.pipeline1_outputs = '0;
        bus.pipeline2_outputs = '0;
        bus.out_valid = 2'b00;
        bus.flush_1 = 1'b0;
        bus.flush_2 = 1'b0;
        bus.stall_en = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");

        // release reset and enable stalls together: the first edge sees cnt=0
        reset_n = 1'b1;
        bus.stall_en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk($sformatf("stall1[%0d]", k), 32'(bus.stall_1), 32'((k % 16) < 3));
            chk($sformatf("stall2[%0d]", k), 32'(bus.stall_2), 32'(((k + 8) % 16) < 3));
        end
        bus.stall_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_off1[%0d]", k), 32'(bus.stall_1), 32'd0);
            chk($sformatf("stall_off2[%0d]", k), 32'(bus.stall_2), 32'd0);
        end

        for (int i = 0; i < 15; i++) begin
            beat(tbl[i].v, tbl[i].d1, tbl[i].d2, tbl[i].f1, tbl[i].f2);
            chk_lanes($sformatf("vec%0d", i), tbl[i].err, tbl[i].m1, tbl[i].m2, tbl[i].mm1, tbl[i].mm2);
        end

        // asynchronous reset while lane 1 is in CHECK: outputs clear without a clock edge
        #2 reset_n = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        beat(2'b11, 32'd50, 32'd0, 1'b0, 1'b0);
        chk_lanes("resync0", 2'b00, 16'd0, 16'd0, 32'd0, 32'd0);
        beat(2'b01, 32'd52, 32'd0, 1'b0, 1'b0);
        chk_lanes("resync1", 2'b00, 16'd1, 16'd0, 32'd0, 32'd0);
        beat(2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
        chk_lanes("lane1_err", 2'b01, 16'd1, 16'd1, 32'd7, 32'd0);
        beat(2'b01, 32'd54, 32'd0, 1'b0, 1'b0);
        chk_lanes("lane1_hold", 2'b01, 16'd1, 16'd1, 32'd7, 32'd0);

        // saturation: one SYNC beat then 65536 matches on lane 2
        beat(2'b00, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 65537; i++) beat(2'b10, 32'd0, 32'(2 * i), 1'b0, 1'b0);
        chk("sat.mc2", 32'(bus.match_count_2), 32'hFFFF);
        chk("sat.err", 32'(bus.err), 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
